// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared widths, reset constants, FSM encoding and configuration
//            record for the PWM ramp controller.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int C_CNT_W      = 18;
    localparam int C_STEP_W     = 8;
    localparam int C_DIV_W      = 8;
    localparam int C_RST_PERIOD = 200000;

    // Controller states, kept as plain constants for legacy tool flows
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RAMP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // One accepted configuration as held in the shadow registers
    typedef struct packed {
        logic [C_CNT_W-1:0]  period;
        logic [C_CNT_W-1:0]  target;
        logic [C_STEP_W-1:0] step;
        logic [C_DIV_W-1:0]  div;
    } pwm_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_step.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_step
// Brief    : Combinational next-duty computation. Moves the current duty one
//            step toward the target, saturating at the target in either
//            direction. A zero step jumps straight to the target.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_step #(
    parameter int CNT_W  = 18,
    parameter int STEP_W = 8
) (
    input  logic [CNT_W-1:0]  i_cur,
    input  logic [CNT_W-1:0]  i_target,
    input  logic [STEP_W-1:0] i_step,
    output logic [CNT_W-1:0]  o_next,
    output logic              o_reached
);

    logic [CNT_W:0]   w_cur_x;
    logic [CNT_W:0]   w_tgt_x;
    logic [CNT_W:0]   w_step_x;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_gap;
    logic [CNT_W-1:0] w_diff;

    // One extra bit on the upward sum so values near full scale cannot wrap
    assign w_cur_x  = {1'b0, i_cur};
    assign w_tgt_x  = {1'b0, i_target};
    assign w_step_x = {{(CNT_W+1-STEP_W){1'b0}}, i_step};
    assign w_sum    = w_cur_x + w_step_x;
    assign w_gap    = w_cur_x - w_tgt_x;
    assign w_diff   = i_cur - w_step_x[CNT_W-1:0];

    // Direction-aware step; any overshoot collapses onto the target
    always_comb begin
        o_next = i_target;
        if ((i_step != '0) && (i_cur != i_target)) begin
            if (i_cur < i_target) begin
                if (w_sum < w_tgt_x) begin
                    o_next = w_sum[CNT_W-1:0];
                end
            end else begin
                if (w_step_x < w_gap) begin
                    o_next = w_diff;
                end
            end
        end
        o_reached = (o_next == i_target);
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Brief    : Accepts period/target configurations, applies them on PWM period
//            boundaries and ramps the live duty toward the target. Dropping
//            enable ramps the duty down to zero and parks in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W      = C_CNT_W,
    parameter int STEP_W     = C_STEP_W,
    parameter int DIV_W      = C_DIV_W,
    parameter int RST_PERIOD = C_RST_PERIOD
) (
    input  logic              in_10Mhz,
    input  logic              reset,
    input  logic              enable,
    input  logic              period_end,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_target,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [CNT_W-1:0]  pwm_period,
    output logic [CNT_W-1:0]  pwm_duty,
    output logic              pwm_load,
    output logic              busy,
    output logic              at_target,
    output logic              cfg_err
);

    logic [1:0]       r_state;
    pwm_cfg_t         r_shadow;
    logic [CNT_W-1:0] r_target;
    logic             r_stopping;
    logic [DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic             r_load;
    logic             r_busy;
    logic             r_at_target;
    logic             r_cfg_ready;
    logic             r_cfg_err;

    logic             w_accept;
    logic             w_cfg_ok;
    logic [CNT_W-1:0] w_clamp;
    logic [CNT_W-1:0] w_step_duty;
    logic             w_step_reached;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_target_nxt;
    logic             w_stopping_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    logic             w_load_nxt;

    assign w_accept = cfg_valid & r_cfg_ready;
    assign w_cfg_ok = (cfg_target <= cfg_period) && (cfg_period != '0);
    // Shrinking the period must never leave duty above it
    assign w_clamp  = (r_duty > r_shadow.period) ? r_shadow.period : r_duty;

    pwm_ramp_step #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) u_step (
        .i_cur     (r_duty),
        .i_target  (r_target),
        .i_step    (r_shadow.step),
        .o_next    (w_step_duty),
        .o_reached (w_step_reached)
    );

    // Next-state logic: normal sequencing first, then soft-stop override
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_stopping_nxt = r_stopping;
        w_div_nxt      = '0;
        w_period_nxt   = r_period;
        w_duty_nxt     = r_duty;
        w_load_nxt     = 1'b0;

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                // An accept in the same cycle as period_end defers the load
                if (w_accept && w_cfg_ok) begin
                    w_state_nxt    = ST_LOAD;
                    w_target_nxt   = cfg_target;
                    w_stopping_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (period_end) begin
                    w_period_nxt = r_shadow.period;
                    w_duty_nxt   = w_clamp;
                    w_load_nxt   = 1'b1;
                    w_state_nxt  = (w_clamp == r_target) ? ST_HOLD : ST_RAMP;
                end
            end
            default: begin
                w_div_nxt = r_div_cnt;
                if (period_end) begin
                    if (r_div_cnt == r_shadow.div) begin
                        w_div_nxt  = '0;
                        w_duty_nxt = w_step_duty;
                        w_load_nxt = 1'b1;
                        if (w_step_reached) begin
                            w_state_nxt = r_stopping ? ST_IDLE : ST_HOLD;
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + DIV_W'(1);
                    end
                end
            end
        endcase

        // Soft stop: aim for zero with the current step/divider settings
        if (!enable && (r_state != ST_IDLE)) begin
            w_target_nxt   = '0;
            w_stopping_nxt = 1'b1;
            if (r_state != ST_RAMP) begin
                w_state_nxt  = (r_duty == '0) ? ST_IDLE : ST_RAMP;
                w_period_nxt = r_period;
                w_duty_nxt   = r_duty;
                w_load_nxt   = 1'b0;
                w_div_nxt    = '0;
            end
        end
    end

    // State, shadow and output registers
    always_ff @(posedge in_10Mhz or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_target    <= '0;
            r_stopping  <= 1'b0;
            r_div_cnt   <= '0;
            r_period    <= CNT_W'(RST_PERIOD);
            r_duty      <= '0;
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_stopping  <= w_stopping_nxt;
            r_div_cnt   <= w_div_nxt;
            r_period    <= w_period_nxt;
            r_duty      <= w_duty_nxt;
            r_load      <= w_load_nxt;
            r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RAMP);
            r_at_target <= (w_state_nxt == ST_HOLD);
            r_cfg_ready <= enable &&
                           ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD));
            if (w_accept) begin
                r_cfg_err <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_shadow <= '{period: cfg_period, target: cfg_target,
                                  step: cfg_step, div: cfg_div};
                end
            end
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign pwm_period = r_period;
    assign pwm_duty   = r_duty;
    assign pwm_load   = r_load;
    assign busy       = r_busy;
    assign at_target  = r_at_target;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencer and configurator for the 18-bit free-running PWM datapath clocked at 10 MHz.
- Accepts a new period/target-duty configuration over a valid/ready handshake.
- Applies it only at PWM period boundaries, so there are no runt pulses.
- Ramps the live duty toward the target in programmable steps (soft-start/soft-stop).
- Drives the period/duty/load inputs of the PWM core; the core returns a wrap pulse.

Parameters:
CNT_W, 18, width of PWM counter, period and duty values
STEP_W, 8, width of duty step size
DIV_W, 8, width of ramp divider (periods per step, minus one)
RST_PERIOD, 200000, period value driven after reset (50 Hz at 10 MHz)

Ports:
in_10Mhz  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  level; low requests soft stop to duty 0
period_end  input  1  one-cycle pulse from PWM core on counter wrap
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted this cycle
cfg_period  input  CNT_W  new period (counts per PWM cycle)
cfg_target  input  CNT_W  new target duty (high counts)
cfg_step  input  STEP_W  duty increment per ramp step; 0 means jump directly
cfg_div  input  DIV_W  ramp step every cfg_div+1 periods
pwm_period  output  CNT_W  live period to PWM core
pwm_duty  output  CNT_W  live duty to PWM core
pwm_load  output  1  one-cycle strobe: core latches period/duty
busy  output  1  high in LOAD or RAMP
at_target  output  1  pwm_duty == active target, state HOLD
cfg_err  output  1  sticky: rejected config (target > period, or period == 0)

Behaviour:
- Reset (reset low, async) values:
  - state IDLE; pwm_period = RST_PERIOD; pwm_duty = 0.
  - pwm_load, busy, at_target, cfg_err = 0; cfg_ready = 1.
  - Shadow registers and divider count = 0.
- States: IDLE, LOAD, RAMP, HOLD. All outputs are registered.
- cfg_ready:
  - High in IDLE and HOLD when enable = 1.
  - Low in LOAD and RAMP.
  - Low when enable = 0.
- Handshake: accept when cfg_valid & cfg_ready on a rising edge.
  - Valid config (cfg_target <= cfg_period, cfg_period != 0): copy all four fields to shadow registers; next state LOAD.
  - Invalid config: set cfg_err; state unchanged; nothing shadowed.
  - cfg_err clears only on reset or on the next valid accept.
- LOAD: wait for period_end.
  - Set pwm_period = shadow period.
  - Set pwm_duty = min(current pwm_duty, shadow period), which guarantees duty <= period.
  - Pulse pwm_load.
  - Go to RAMP, or to HOLD if pwm_duty already equals the target.
- RAMP: count period_end pulses in the divider.
  - On the (cfg_div+1)th pulse, move duty one step toward the target, reset the divider and pulse pwm_load.
  - Step is duty ± step, saturating at the target with no overshoot.
  - cfg_step = 0 jumps to the target in one update.
  - Reaching the target moves to HOLD.
- HOLD: at_target = 1; outputs stable; a new config may be accepted (goes to LOAD).
- Output timing: pwm_duty/pwm_period change and pwm_load = 1 in the cycle after the sampled period_end. pwm_load is exactly one cycle wide.
- Duty arithmetic: CNT_W-bit unsigned; the step is zero-extended. Compute the sum in CNT_W+1 bits before comparing with the target, so nothing wraps at 2^18−1.
- enable falling (any state):
  - Active target forced to 0; period kept; go to RAMP (ramp down with current step/divider).
  - When duty reaches 0, go to IDLE.
  - enable rising in IDLE does not auto-restart; a new config is needed.
- period_end while not in LOAD/RAMP: ignored; divider held at 0.
- period_end and cfg accept in the same cycle (HOLD): the accept wins; the boundary is not used for loading; the update waits for the next period_end.
- Reset mid-ramp: immediate return to reset values; pwm_load not asserted.

Decomposition:
- Package pwm_pkg:
  - state enum (IDLE, LOAD, RAMP, HOLD).
  - CNT_W/STEP_W/DIV_W defaults, RST_PERIOD constant.
  - cfg struct {period, target, step, div}.
- One natural sub-module: pwm_ramp_step. It is combinational next-duty computation (current, target, step → next, reached), saturating and direction-aware. The FSM, shadow registers and divider stay in the top module.

Test Plan:
1. Reset then idle: reset low 3 cycles, release → pwm_period = 200000, pwm_duty = 0, cfg_ready = 1, no pwm_load for 1000 cycles without config.
2. Ramp up: cfg period = 1000, target = 100, step = 30, div = 1; period_end every 1000 cycles → pwm_load sequence:
   - duty 0 at first period_end (period load);
   - then 30, 60, 90, 100 on every 2nd period_end;
   - then HOLD, at_target = 1.
3. Invalid config: target = 1500, period = 1000 → cfg_err = 1, state/outputs unchanged. The next valid config clears cfg_err.
4. Soft stop: in HOLD at duty 100, step 30, div 0, drop enable → duty 70, 40, 10, 0 on successive period_end, then IDLE with busy = 0.
5. Period shrink: HOLD at duty 800 / period 1000; cfg period = 500, target = 400, step = 0 → LOAD gives period 500, duty 500 (clamped); next period_end gives duty 400, HOLD.
6. Collision and reset: period_end and cfg accept in the same cycle → no pwm_load that cycle; load at the next period_end. Assert reset during RAMP → outputs return to reset values asynchronously.
